// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared state encoding and fault cause codes for the data memory bridge
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_BUS      = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;
  localparam logic [1:0] FAULT_MISALIGN = 2'd3;

endpackage

// File: rtl/data_mem_bridge_if.sv
// rtl/data_mem_bridge_if.sv - req/ack memory bus between the bridge (master) and a slave
interface data_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata, bus_err
  );
endinterface

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - counts REQ cycles and flags the last permitted one
module mem_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Count wait cycles; clear has priority so a fresh request always starts at 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // Expired marks the final REQ cycle, so bus_req is high for exactly TIMEOUT cycles
  assign expired = (count == LAST);
endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - turns core load/store requests into registered req/ack bus transactions
module data_mem_bridge
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              should_read_mem,
  input  logic              should_write_mem,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              mem_stall,
  output logic              mem_fault,
  output logic [1:0]        fault_cause,
  data_mem_bridge_if.master bus
);
  state_t state, state_next;

  logic              op;
  logic              stall;
  logic              capture;
  logic              cnt_clear;
  logic              cnt_en;
  logic              expired;
  logic              set_fault;
  logic [1:0]        fault_code;
  logic              clr_rdata;
  logic              load_rdata;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic              fault_q;
  logic [1:0]        cause_q;

  assign op = should_read_mem | should_write_mem;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    capture    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    set_fault  = 1'b0;
    fault_code = FAULT_NONE;
    clr_rdata  = 1'b0;
    load_rdata = 1'b0;
    case (state)
      IDLE: begin
        stall = op;
        if (op) begin
          capture = 1'b1;
          if (data_addr[1:0] != 2'b00) begin
            set_fault  = 1'b1;
            fault_code = FAULT_MISALIGN;
            clr_rdata  = 1'b1;
            state_next = DONE;
          end else begin
            cnt_clear  = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.bus_err) begin
          set_fault  = 1'b1;
          fault_code = FAULT_BUS;
          clr_rdata  = 1'b1;
          state_next = DONE;
        end else if (bus.bus_ack) begin
          load_rdata = ~we_q;
          state_next = DONE;
        end else if (expired) begin
          set_fault  = 1'b1;
          fault_code = FAULT_TIMEOUT;
          clr_rdata  = 1'b1;
          state_next = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, read-data return and first-fault-wins latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cause_q <= FAULT_NONE;
    end else begin
      if (capture) begin
        addr_q  <= data_addr;
        wdata_q <= mem_write_data;
        we_q    <= should_write_mem;
      end
      if (clr_rdata) begin
        rdata_q <= '0;
      end else if (load_rdata) begin
        rdata_q <= bus.bus_rdata;
      end
      if (set_fault && !fault_q) begin
        fault_q <= 1'b1;
        cause_q <= fault_code;
      end
    end
  end

  // Stall is gated by reset so the core never sees it while the bridge is held in reset
  assign mem_stall     = stall & reset;
  assign mem_read_data = rdata_q;
  assign mem_fault     = fault_q;
  assign fault_cause   = cause_q;

  assign bus.bus_req   = (state == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - self-checking bench for data_mem_bridge
module tb_data_mem_bridge;
  logic        clk;
  logic        reset;
  logic [31:0] data_addr;
  logic        should_read_mem;
  logic        should_write_mem;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_stall;
  logic        mem_fault;
  logic [1:0]  fault_cause;

  int errors = 0;
  int checks = 0;

  data_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  data_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .data_addr        (data_addr),
    .should_read_mem  (should_read_mem),
    .should_write_mem (should_write_mem),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .mem_stall        (mem_stall),
    .mem_fault        (mem_fault),
    .fault_cause      (fault_cause),
    .bus              (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    int          resp;
    logic [31:0] rdata;
    int          exp_req;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    should_read_mem  = 1'b0;
    should_write_mem = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // resp: 0 = ack, 1 = err, 2 = ack and err together; response comes after 'waits' REQ cycles
  task automatic do_op(input logic [31:0] addr, input logic rd, input logic wr,
                       input logic [31:0] wdata, input int waits, input int resp,
                       input logic [31:0] rdata, output int req_n, output int stall_n,
                       output logic bus_ok, output logic first_stall,
                       output logic [31:0] rdata_o, output logic fault_o,
                       output logic [1:0] cause_o);
    logic done;
    req_n = 0;
    stall_n = 0;
    bus_ok = 1'b1;
    done = 1'b0;
    first_stall = 1'b0;
    @(negedge clk);
    data_addr        = addr;
    should_read_mem  = rd;
    should_write_mem = wr;
    mem_write_data   = wdata;
    for (int i = 0; i < 40; i++) begin
      bus_if.bus_ack = 1'b0;
      bus_if.bus_err = 1'b0;
      #1;
      if (i == 0) first_stall = mem_stall;
      if (!mem_stall) begin
        done = 1'b1;
        if (bus_if.bus_req !== 1'b0) bus_ok = 1'b0;
        break;
      end
      stall_n++;
      if (bus_if.bus_req) begin
        req_n++;
        if (bus_if.bus_we !== wr || bus_if.bus_addr !== addr) bus_ok = 1'b0;
        if (wr && bus_if.bus_wdata !== wdata) bus_ok = 1'b0;
        if (req_n > waits) begin
          bus_if.bus_rdata = rdata;
          bus_if.bus_ack = (resp != 1);
          bus_if.bus_err = (resp != 0);
        end
      end
      @(negedge clk);
    end
    chk("op_completes", {31'b0, done}, 32'd1);
    rdata_o = mem_read_data;
    fault_o = mem_fault;
    cause_o = fault_cause;
    should_read_mem  = 1'b0;
    should_write_mem = 1'b0;
  endtask

  int          rq, st;
  logic        ok, fs, flt;
  logic [31:0] rdo;
  logic [1:0]  cs;

  initial begin
    //        addr          rd wr wdata         waits resp rdata         req stall exp_rdata     flt cause
    vecs[0] = '{32'h100,   1, 0, 32'h0,        0,  0, 32'hDEADBEEF,  1,  2, 32'hDEADBEEF, 0, 2'd0};
    vecs[1] = '{32'h204,   0, 1, 32'h12345678, 3,  0, 32'hFFFFFFFF,  4,  5, 32'h0,        0, 2'd0};
    vecs[2] = '{32'h103,   1, 0, 32'h0,        0,  0, 32'h55555555,  0,  1, 32'h0,        1, 2'd3};
    vecs[3] = '{32'h8,     1, 0, 32'h0,        2,  1, 32'h99999999,  3,  4, 32'h0,        1, 2'd1};
    vecs[4] = '{32'h10,    1, 1, 32'hA0A0A0A0, 1,  0, 32'h77777777,  2,  3, 32'h0,        0, 2'd0};
    vecs[5] = '{32'h202,   0, 1, 32'h1,        0,  0, 32'h0,         0,  1, 32'h0,        1, 2'd3};
    vecs[6] = '{32'h3C,    1, 0, 32'h0,        3,  0, 32'hA5A5A5A5,  4,  5, 32'hA5A5A5A5, 0, 2'd0};

    reset = 1'b0;
    data_addr = 32'h100;
    should_read_mem = 1'b1;
    should_write_mem = 1'b0;
    mem_write_data = 32'h0;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_err = 1'b0;
    bus_if.bus_rdata = 32'h0;

    // Reset state with a request pending: stall must still be low
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", {31'b0, mem_stall}, 32'd0);
    chk("reset_req", {31'b0, bus_if.bus_req}, 32'd0);
    chk("reset_rdata", mem_read_data, 32'd0);
    chk("reset_cause", {29'b0, mem_fault, fault_cause}, 32'd0);
    should_read_mem = 1'b0;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      do_op(vecs[v].addr, vecs[v].rd, vecs[v].wr, vecs[v].wdata, vecs[v].waits,
            vecs[v].resp, vecs[v].rdata, rq, st, ok, fs, rdo, flt, cs);
      chk($sformatf("v%0d_req_cycles", v), rq, vecs[v].exp_req);
      chk($sformatf("v%0d_stall_cycles", v), st, vecs[v].exp_stall);
      chk($sformatf("v%0d_bus_stable", v), {31'b0, ok}, 32'd1);
      chk($sformatf("v%0d_rdata", v), rdo, vecs[v].exp_rdata);
      chk($sformatf("v%0d_fault", v), {31'b0, flt}, {31'b0, vecs[v].exp_fault});
      chk($sformatf("v%0d_cause", v), {30'b0, cs}, {30'b0, vecs[v].exp_cause});
    end

    // Timeout after exactly 4 REQ cycles, then a later bus_err cannot overwrite the cause
    do_reset();
    do_op(32'h40, 1, 0, 0, 1000, 0, 32'h0, rq, st, ok, fs, rdo, flt, cs);
    chk("to_req_cycles", rq, 4);
    chk("to_stall_cycles", st, 5);
    chk("to_cause", {30'b0, cs}, 32'd2);
    chk("to_fault", {31'b0, flt}, 32'd1);
    do_op(32'h44, 1, 0, 0, 0, 1, 32'h0, rq, st, ok, fs, rdo, flt, cs);
    chk("to_sticky_cause", {30'b0, cs}, 32'd2);

    // Back-to-back: good read, then simultaneous ack+err read immediately after DONE
    do_reset();
    do_op(32'h20, 1, 0, 0, 0, 0, 32'h11, rq, st, ok, fs, rdo, flt, cs);
    chk("b2b_first_rdata", rdo, 32'h11);
    do_op(32'h24, 1, 0, 0, 0, 2, 32'h22, rq, st, ok, fs, rdo, flt, cs);
    chk("b2b_stall_immediate", {31'b0, fs}, 32'd1);
    chk("both_rdata", rdo, 32'h0);
    chk("both_cause", {30'b0, cs}, 32'd1);

    // Asynchronous reset mid-REQ clears everything before the next edge
    do_reset();
    do_op(32'h31, 1, 0, 0, 0, 0, 32'h0, rq, st, ok, fs, rdo, flt, cs);
    do_op(32'h30, 1, 0, 0, 0, 0, 32'hCAFE, rq, st, ok, fs, rdo, flt, cs);
    chk("pre_rst_rdata", rdo, 32'hCAFE);
    chk("pre_rst_cause", {30'b0, cs}, 32'd3);
    @(negedge clk);
    data_addr = 32'h300;
    should_read_mem = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_req_active", {31'b0, bus_if.bus_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req", {31'b0, bus_if.bus_req}, 32'd0);
    chk("arst_stall", {31'b0, mem_stall}, 32'd0);
    chk("arst_addr", bus_if.bus_addr, 32'd0);
    chk("arst_rdata", mem_read_data, 32'd0);
    chk("arst_fault", {29'b0, mem_fault, fault_cause}, 32'd0);
    @(negedge clk);
    should_read_mem = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_op(32'h304, 1, 0, 0, 0, 0, 32'h77, rq, st, ok, fs, rdo, flt, cs);
    chk("post_rst_rdata", rdo, 32'h77);
    chk("post_rst_stall", st, 2);
    chk("post_rst_cause", {29'b0, flt, cs}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
